// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined Brent-Kung carry-lookahead adder/subtractor with valid/ready handshake
// Define CLA_SAT_EN to clamp overflowing results to the signed extreme instead of wrapping.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG = $clog2(WIDTH);
  localparam int NL  = 2 * LOG - 1;

  typedef struct packed {
`ifdef CLA_SAT_EN
    logic             asign;
`endif
    logic             c0;
    logic [WIDTH-1:0] pb;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
  } lv_t;

  // Internal register k sits after prefix level ((k+1)*NL)/PIPE; the last stage is the output register.
  function automatic int stage_at(input int l);
    int r;
    r = -1;
    for (int k = 0; k < PIPE - 1; k++)
      if ((k + 1) * NL / PIPE == l) r = k;
    return r;
  endfunction

  // Levels 1..LOG are the up-sweep, LOG+1..NL the down-sweep.
  function automatic lv_t prefix_level(input int l, input lv_t x);
    lv_t y;
    int  d;
    int  j;
    y = x;
    d = (l <= LOG) ? (1 << l) : (1 << (2 * LOG - l));
    for (int i = 0; i < WIDTH; i++) begin
      if ((l <= LOG) ? ((i + 1) % d == 0) : (((i + 1) % d == d / 2) && (i >= d))) begin
        j = i - d / 2;
        y.g[i] = x.g[i] | (x.p[i] & x.g[j]);
        y.p[i] = x.p[i] & x.p[j];
      end
    end
    return y;
  endfunction

  logic [PIPE-1:0]  v;
  logic [PIPE-1:0]  rdy;
  logic [PIPE-1:0]  ld;
  logic             chain;
  logic [WIDTH-1:0] bx;

  assign bx = sub ? ~b : b;

  always_comb begin
    rdy   = '0;
    ld    = '0;
    chain = out_ready;
    for (int k = PIPE - 1; k >= 0; k--) begin
      chain  = chain | ~v[k];
      rdy[k] = chain;
    end
    ld[0] = rdy[0] & in_valid;
    for (int k = 1; k < PIPE; k++) ld[k] = rdy[k] & v[k-1];
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[PIPE-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else begin
      if (rdy[0]) v[0] <= in_valid;
      for (int k = 1; k < PIPE; k++)
        if (rdy[k]) v[k] <= v[k-1];
    end
  end

  for (genvar l = 0; l <= NL; l++) begin : g_st
    localparam int K = stage_at(l);
    lv_t d;
    lv_t q;
    if (l == 0) begin : g_in
      always_comb begin
        d    = '0;
        d.g  = a & bx;
        d.p  = a ^ bx;
        d.pb = a ^ bx;
        d.c0 = sub ? 1'b1 : cin;
`ifdef CLA_SAT_EN
        d.asign = a[WIDTH-1];
`endif
      end
    end else begin : g_lvl
      always_comb d = prefix_level(l, g_st[l-1].q);
    end
    // Data only loads with a valid beat, so bubbles never disturb held values.
    if (K >= 0) begin : g_reg
      always_ff @(posedge clk) begin
        if (reset)      q <= '0;
        else if (ld[K]) q <= d;
      end
    end else begin : g_thru
      assign q = d;
    end
  end

  lv_t              f;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_n;
  logic             ovf_n;

  assign f     = g_st[NL].q;
  assign c     = {f.g | (f.p & {WIDTH{f.c0}}), f.c0};
  assign ovf_n = c[WIDTH] ^ c[WIDTH-1];

`ifdef CLA_SAT_EN
  always_comb begin
    sum_n = f.pb ^ c[WIDTH-1:0];
    if (ovf_n) sum_n = f.asign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign sum_n = f.pb ^ c[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (ld[PIPE-1]) begin
      sum  <= sum_n;
      cout <= c[WIDTH];
      ovf  <= ovf_n;
    end
  end

endmodule
